leakyrelu_sched: RTL

Sequencer for the per-channel leakyrelu datapath array. It runs one feature-map pass per start: it latches the zero point and geometry, streams input beats into the array, and tracks the array's fixed pipeline latency with a valid shift register. It issues beats only when the downstream result FIFO has credit, then signals done after the pipeline drains. It sits between the convolution/requant output FIFO and the write-back FIFO in the TJPU datapath.

---
 rtl/leakyrelu_sched_pkg.sv | 17 +
 rtl/leakyrelu_sched_if.sv | 22 ++
 rtl/leakyrelu_sched_credit_cnt.sv | 31 +++
 rtl/leakyrelu_sched.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/leakyrelu_sched_pkg.sv
// Shared types and defaults for the leakyrelu pass sequencer.
// Optional build macro: LEAKY_SCHED_PERF_EN adds the stall_cnt port.
package leakyrelu_sched_pkg;

    localparam int PICTURE_NUM       = 1;
    localparam int WIDTH_DATA        = 8;
    localparam int LEAKY_LATENCY_DEF = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/leakyrelu_sched_if.sv
// Input beat stream and result stream bundle for the sequencer.
// master = producer/consumer side, slave = sequencer side.
interface leakyrelu_sched_if #(
    parameter int DW = 64
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_pop;

    modport master (
        output in_data, in_valid, out_pop,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_pop,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/leakyrelu_sched_credit_cnt.sv
// Downstream FIFO credit counter; saturates at full and flags
// a sticky error when a pop arrives with every credit already home.
module leakyrelu_credit_cnt #(
    parameter int OUT_CREDITS = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               issue,
    input  logic                               pop,
    output logic [$clog2(OUT_CREDITS+1)-1:0]   credits,
    output logic                               err
);
    localparam int CRW = $clog2(OUT_CREDITS + 1);
    localparam logic [CRW-1:0] FULL = CRW'(OUT_CREDITS);
    localparam logic [CRW-1:0] ONE  = CRW'(1);

    // credits = credits - issue + pop, pop at full is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= FULL;
            err     <= 1'b0;
        end else if (pop && !issue && credits == FULL) begin
            err     <= 1'b1;
        end else if (issue && !pop) begin
            credits <= credits - ONE;
        end else if (pop && !issue) begin
            credits <= credits + ONE;
        end
    end

endmodule

// File: rtl/leakyrelu_sched.sv
// One-pass sequencer feeding the leakyrelu array with credit flow control.
// Build with LEAKY_SCHED_PERF_EN to get the stall_cnt counter port.
module leakyrelu_sched
    import leakyrelu_sched_pkg::*;
#(
    parameter int CHANNEL_OUT_NUM = 8,
    parameter int LEAKY_LATENCY   = LEAKY_LATENCY_DEF,
    parameter int CNT_WIDTH       = 12,
    parameter int OUT_CREDITS     = 16,
    localparam int DW = PICTURE_NUM * CHANNEL_OUT_NUM * WIDTH_DATA
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           zero_in,
    input  logic [CNT_WIDTH-1:0] row_num,
    input  logic [CNT_WIDTH-1:0] col_num,
    input  logic [CNT_WIDTH-1:0] ch_grp_num,
    leakyrelu_sched_if.slave     bus,
    output logic [DW-1:0]        leaky_data_in,
    output logic [7:0]           zero_data_out,
    input  logic [DW-1:0]        leaky_data_out,
    output logic                 busy,
    output logic                 done
`ifdef LEAKY_SCHED_PERF_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);
    localparam int CRW = $clog2(OUT_CREDITS + 1);
    localparam logic [CNT_WIDTH-1:0] C1 = CNT_WIDTH'(1);

    state_t               state, state_nx;
    logic [LEAKY_LATENCY:0] vsr;
    logic [CRW-1:0]       credits;
    logic                 cr_err_unused;
    logic                 issue;
    logic                 last_beat;
    logic                 load_empty;
    logic [CNT_WIDTH-1:0] row_n, col_n, grp_n;
    logic [CNT_WIDTH-1:0] row_c, col_c, grp_c;

    assign load_empty = (row_num == '0) || (col_num == '0) ||
                        (ch_grp_num == '0);
    assign issue      = bus.in_ready;
    assign last_beat  = (col_c == col_n - C1) && (row_c == row_n - C1) &&
                        (grp_c == grp_n - C1);

    assign bus.in_ready  = (state == S_RUN) && bus.in_valid &&
                           (credits != '0);
    assign bus.out_valid = vsr[LEAKY_LATENCY];
    assign bus.out_data  = leaky_data_out;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);

    leakyrelu_credit_cnt #(
        .OUT_CREDITS (OUT_CREDITS)
    ) u_credit (
        .clk     (clk),
        .rst     (rst),
        .issue   (issue),
        .pop     (bus.out_pop),
        .credits (credits),
        .err     (cr_err_unused)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // next-state decode
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD:  state_nx = load_empty ? S_DONE : S_RUN;
            S_RUN:   if (issue && last_beat) state_nx = S_DRAIN;
            S_DRAIN: if (vsr == '0) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // pass geometry latch and col/row/group beat position
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_data_out <= '0;
            row_n <= '0;
            col_n <= '0;
            grp_n <= '0;
            row_c <= '0;
            col_c <= '0;
            grp_c <= '0;
        end else if (state == S_LOAD) begin
            zero_data_out <= zero_in;
            row_n <= row_num;
            col_n <= col_num;
            grp_n <= ch_grp_num;
            row_c <= '0;
            col_c <= '0;
            grp_c <= '0;
        end else if (issue) begin
            if (col_c == col_n - C1) begin
                col_c <= '0;
                if (row_c == row_n - C1) begin
                    row_c <= '0;
                    grp_c <= grp_c + C1;
                end else begin
                    row_c <= row_c + C1;
                end
            end else begin
                col_c <= col_c + C1;
            end
        end
    end

    // input register into the array and latency tracker
    always_ff @(posedge clk) begin
        if (rst) begin
            leaky_data_in <= '0;
            vsr           <= '0;
        end else begin
            vsr <= {vsr[LEAKY_LATENCY-1:0], issue};
            if (issue) leaky_data_in <= bus.in_data;
        end
    end

`ifdef LEAKY_SCHED_PERF_EN
    // cycles lost waiting for downstream credit
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (state == S_LOAD)
            stall_cnt <= '0;
        else if (state == S_RUN && bus.in_valid && credits == '0)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule
